// File: rtl/sum_capture_pkg.sv
// Shared types and widths for the sum_capture result-capture block.
// Entry width grows by TS_W when SUM_CAPTURE_TIMESTAMP_EN is defined.
package sum_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    STOPPED = 2'd2
  } state_t;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned TS_W  = 32;

  // Stored entry: {[ts,] err, sum, b, a}
  function automatic int unsigned entry_w(input int unsigned w);
`ifdef SUM_CAPTURE_TIMESTAMP_EN
    return 3 * w + 2 + TS_W;
`else
    return 3 * w + 2;
`endif
  endfunction

endpackage

// File: rtl/sum_capture_fifo.sv
// Generic first-word-fall-through circular buffer with wrap-bit pointers.
module sum_capture_fifo #(
  parameter int unsigned WIDTH = 26,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == PW'(DEPTH));
  assign empty   = (wr_ptr == rd_ptr);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage is not reset; empty masks stale contents on rdata.
  always_ff @(posedge clk) begin
    if (do_push && !rst && !clr) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/sum_capture.sv
// Checks sum == a + b on each captured sample and buffers tagged results.
// Optional SUM_CAPTURE_TIMESTAMP_EN adds a 32-bit write-time stamp per entry.
module sum_capture
  import sum_capture_pkg::*;
#(
  parameter int unsigned W            = 8,
  parameter int unsigned DEPTH        = 8,
  parameter bit          STOP_ON_FULL = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arm,
  input  logic                     clr,
  input  logic                     in_valid,
  input  logic [W-1:0]             in_a,
  input  logic [W-1:0]             in_b,
  input  logic [W:0]               in_sum,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [entry_w(W)-1:0]    rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic [CNT_W-1:0]         err_count,
  output logic [CNT_W-1:0]         drop_count,
  output logic                     capturing
);

  localparam int unsigned EW = entry_w(W);
  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = W + 1;

  state_t          state_q;
  state_t          state_d;
  logic            err_c;
  logic            push_c;
  logic            pop_c;
  logic            drop_c;
  logic [SW-1:0]   sum_ref_c;
  logic [EW-1:0]   wdata_c;

  assign capturing = (state_q == CAPTURE);
  assign rd_valid  = !empty;
  assign pop_c     = rd_valid && rd_ready && !clr;
  assign push_c    = capturing && in_valid && !clr && (!full || pop_c);
  assign drop_c    = capturing && in_valid && !clr && full && !pop_c;
  assign sum_ref_c = SW'(in_a) + SW'(in_b);
  assign err_c     = (sum_ref_c != in_sum);

`ifdef SUM_CAPTURE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge clk) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_q + TS_W'(1);
  end

  assign wdata_c = {ts_q, err_c, in_sum, in_b, in_a};
`else
  assign wdata_c = {err_c, in_sum, in_b, in_a};
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Stop only on the write that fills the last slot.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arm) state_d = CAPTURE;
      CAPTURE: if (STOP_ON_FULL && push_c && !pop_c && (level == LW'(DEPTH - 1)))
                 state_d = STOPPED;
      STOPPED: if (arm) state_d = CAPTURE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      err_count  <= '0;
      drop_count <= '0;
    end else begin
      if (push_c && err_c && (err_count != '1)) err_count  <= err_count + CNT_W'(1);
      if (drop_c && (drop_count != '1))         drop_count <= drop_count + CNT_W'(1);
    end
  end

  sum_capture_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (push_c),
    .pop   (pop_c),
    .wdata (wdata_c),
    .rdata (rd_data),
    .level (level),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_sum_capture.sv
// Directed bench for sum_capture (W=8, DEPTH=4): drop mode and stop-on-full mode.
module tb_sum_capture;
  import sum_capture_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 4;
  localparam int unsigned EW = entry_w(W);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           arm = 1'b0, clr = 1'b0, in_valid = 1'b0, rd_ready = 1'b0;
  logic [W-1:0]   in_a = '0, in_b = '0;
  logic [W:0]     in_sum = '0;
  logic           rd_valid, full, empty, capturing;
  logic [EW-1:0]  rd_data;
  logic [2:0]     level;
  logic [15:0]    err_count, drop_count;

  logic           s_arm = 1'b0, s_clr = 1'b0, s_valid = 1'b0, s_ready = 1'b0;
  logic           s_rd_valid, s_full, s_empty, s_capturing;
  logic [EW-1:0]  s_rd_data;
  logic [2:0]     s_level;
  logic [15:0]    s_err_count, s_drop_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [25:0] q[$];

  always #5 clk = ~clk;

  sum_capture #(.W(W), .DEPTH(D), .STOP_ON_FULL(1'b0)) u_dut (
    .clk(clk), .rst(rst), .arm(arm), .clr(clr), .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b), .in_sum(in_sum), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .level(level), .full(full),
    .empty(empty), .err_count(err_count), .drop_count(drop_count),
    .capturing(capturing)
  );

  sum_capture #(.W(W), .DEPTH(D), .STOP_ON_FULL(1'b1)) u_stop (
    .clk(clk), .rst(rst), .arm(s_arm), .clr(s_clr), .in_valid(s_valid),
    .in_a(in_a), .in_b(in_b), .in_sum(in_sum), .rd_ready(s_ready),
    .rd_valid(s_rd_valid), .rd_data(s_rd_data), .level(s_level), .full(s_full),
    .empty(s_empty), .err_count(s_err_count), .drop_count(s_drop_count),
    .capturing(s_capturing)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [25:0] ent(input logic e, input logic [7:0] a,
                                      input logic [7:0] b, input logic [8:0] s);
    return {e, s, b, a};
  endfunction

  // Numbered sample n: a=n+1, b=n+2, sum=2n+3 (always correct)
  task automatic drive_smp(input int n);
    in_a   = 8'(n + 1);
    in_b   = 8'(n + 2);
    in_sum = 9'(2 * n + 3);
  endtask

  function automatic logic [25:0] smp(input int n);
    return ent(1'b0, 8'(n + 1), 8'(n + 2), 9'(2 * n + 3));
  endfunction

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [8:0] s);
    in_a = a; in_b = b; in_sum = s;
  endtask

  initial begin
    logic [25:0] exp3 [3];
    exp3[0] = ent(1'b0, 8'd1, 8'd2, 9'd3);
    exp3[1] = ent(1'b0, 8'd10, 8'd20, 9'd30);
    exp3[2] = ent(1'b0, 8'd255, 8'd255, 9'd510);

    // Reset values
    tick(); tick();
    rst = 1'b0;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data[25:0]), 32'd0);
    check("rst_capturing", 32'(capturing), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);

    // Samples while idle are ignored
    drive(8'd1, 8'd2, 9'd3); in_valid = 1'b1;
    tick(); tick();
    in_valid = 1'b0;
    check("idle_empty", 32'(empty), 32'd1);
    check("idle_level", 32'(level), 32'd0);
    check("idle_capturing", 32'(capturing), 32'd0);
    check("idle_drop", 32'(drop_count), 32'd0);

    // Arm, three good samples, FWFT latency
    arm = 1'b1; tick(); arm = 1'b0;
    check("arm_capturing", 32'(capturing), 32'd1);
    in_valid = 1'b1;
    drive(8'd1, 8'd2, 9'd3); tick();
    check("lat_rd_valid", 32'(rd_valid), 32'd1);
    check("lat_head", 32'(rd_data[25:0]), 32'(exp3[0]));
    drive(8'd10, 8'd20, 9'd30); tick();
    drive(8'd255, 8'd255, 9'd510); tick();
    in_valid = 1'b0;
    check("three_level", 32'(level), 32'd3);
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("drain_valid", 32'(rd_valid), 32'd1);
      check("drain_data", 32'(rd_data[25:0]), 32'(exp3[i]));
      tick();
    end
    rd_ready = 1'b0;
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_rd_data0", 32'(rd_data[25:0]), 32'd0);
    check("drain_err_count", 32'(err_count), 32'd0);

    // Mismatched sum sets err; arm in CAPTURE is ignored
    arm = 1'b1; drive(8'd5, 8'd5, 9'd9); in_valid = 1'b1;
    tick();
    arm = 1'b0; in_valid = 1'b0;
    check("err_capturing", 32'(capturing), 32'd1);
    check("err_entry", 32'(rd_data[25:0]), 32'(ent(1'b1, 8'd5, 8'd5, 9'd9)));
    check("err_count1", 32'(err_count), 32'd1);
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    check("err_drained", 32'(empty), 32'd1);

    // Overfill without reads: 4 kept, 2 dropped
    q.delete();
    in_valid = 1'b1;
    for (int n = 0; n < 6; n++) begin
      drive_smp(n);
      if (n < 4) q.push_back(smp(n));
      tick();
    end
    in_valid = 1'b0;
    check("ovf_full", 32'(full), 32'd1);
    check("ovf_level", 32'(level), 32'd4);
    check("ovf_drop", 32'(drop_count), 32'd2);
    check("ovf_head", 32'(rd_data[25:0]), 32'(q[0]));

    // Full FIFO, push+pop every cycle across two pointer laps
    in_valid = 1'b1; rd_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive_smp(6 + k);
      check("pp_head", 32'(rd_data[25:0]), 32'(q[0]));
      tick();
      void'(q.pop_front());
      q.push_back(smp(6 + k));
      check("pp_level", 32'(level), 32'd4);
    end
    in_valid = 1'b0; rd_ready = 1'b0;
    check("pp_drop", 32'(drop_count), 32'd2);
    check("pp_head_final", 32'(rd_data[25:0]), 32'(q[0]));

    // clr mid-capture discards concurrent push, keeps state
    clr = 1'b1; in_valid = 1'b1; drive_smp(20); rd_ready = 1'b1;
    tick();
    clr = 1'b0; in_valid = 1'b0; rd_ready = 1'b0;
    check("clr_level", 32'(level), 32'd0);
    check("clr_empty", 32'(empty), 32'd1);
    check("clr_err", 32'(err_count), 32'd0);
    check("clr_drop", 32'(drop_count), 32'd0);
    check("clr_capturing", 32'(capturing), 32'd1);
    drive(8'd5, 8'd5, 9'd9); in_valid = 1'b1; tick(); in_valid = 1'b0;
    check("post_clr_level", 32'(level), 32'd1);
    check("post_clr_err", 32'(err_count), 32'd1);

    // rst wins over arm and in_valid
    rst = 1'b1; arm = 1'b1; in_valid = 1'b1;
    tick();
    rst = 1'b0; arm = 1'b0; in_valid = 1'b0;
    check("rst2_capturing", 32'(capturing), 32'd0);
    check("rst2_level", 32'(level), 32'd0);
    check("rst2_empty", 32'(empty), 32'd1);
    check("rst2_rd_valid", 32'(rd_valid), 32'd0);
    check("rst2_rd_data", 32'(rd_data[25:0]), 32'd0);
    check("rst2_err", 32'(err_count), 32'd0);

    // STOP_ON_FULL instance: halts when the 4th write fills the FIFO
    s_arm = 1'b1; tick(); s_arm = 1'b0;
    check("stop_armed", 32'(s_capturing), 32'd1);
    s_valid = 1'b1;
    for (int n = 0; n < 5; n++) begin
      drive_smp(n);
      tick();
    end
    s_valid = 1'b0;
    check("stop_capturing", 32'(s_capturing), 32'd0);
    check("stop_level", 32'(s_level), 32'd4);
    check("stop_full", 32'(s_full), 32'd1);
    check("stop_drop", 32'(s_drop_count), 32'd0);
    s_ready = 1'b1; tick(); s_ready = 1'b0;
    check("stop_pop_level", 32'(s_level), 32'd3);
    check("stop_pop_head", 32'(s_rd_data[25:0]), 32'(smp(1)));
    check("stop_still", 32'(s_capturing), 32'd0);
    s_arm = 1'b1; tick(); s_arm = 1'b0;
    check("rearm_capturing", 32'(s_capturing), 32'd1);
    check("rearm_level", 32'(s_level), 32'd3);
    s_valid = 1'b1; drive_smp(9); tick(); s_valid = 1'b0;
    check("restop_level", 32'(s_level), 32'd4);
    check("restop_capturing", 32'(s_capturing), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sum_capture.md
Name: sum_capture

Overview:
- Result-side counterpart to the adder stimulus driver: the driver writes operands a/b; this block reads back operand/sum triples each clock.
- Checks that sum equals a+b and buffers the tagged results in a circular FIFO.
- The Python/VPI side drains the FIFO through a valid/ready read port.
- Instantiated in the test top next to the adder, between the DUT outputs and the VPI-visible read port.

Parameters:
- W, 8, operand width; sum is W+1 bits.
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- STOP_ON_FULL, 0: when 1, capture halts when the FIFO is full; when 0, new samples are dropped and counted.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- arm  input  1  one-cycle pulse that starts capture.
- clr  input  1  flushes the FIFO and clears counters; state unchanged.
- in_valid  input  1  sample strobe.
- in_a  input  W  operand a.
- in_b  input  W  operand b.
- in_sum  input  W+1  DUT sum output.
- rd_ready  input  1  consumer accepts the head entry.
- rd_valid  output  1  head entry is available.
- rd_data  output  3W+2  {err, in_sum, in_b, in_a} of the head entry.
- level  output  clog2(DEPTH)+1  current occupancy.
- full  output  1  level == DEPTH.
- empty  output  1  level == 0.
- err_count  output  16  saturating count of mismatched samples.
- drop_count  output  16  saturating count of dropped samples.
- capturing  output  1  high while state is CAPTURE.

Behaviour:
- Reset: state IDLE; FIFO empty; all counters 0; rd_valid=0; rd_data=0; full=0; empty=1; level=0; capturing=0.
- States:
  - IDLE, arm=1 -> CAPTURE.
  - CAPTURE, STOP_ON_FULL=1 and a write makes level==DEPTH -> STOPPED.
  - STOPPED, arm=1 -> CAPTURE. The FIFO is not cleared.
  - arm in CAPTURE is ignored.
- Write: happens in CAPTURE when in_valid=1 and (!full or a pop occurs in the same cycle).
- Drop: in_valid=1 in CAPTURE while full with no pop -> sample discarded, drop_count+1. Only possible with STOP_ON_FULL=0.
- in_valid outside CAPTURE is ignored and not counted.
- err bit: (in_a + in_b), computed zero-extended to W+1 bits, != in_sum. No truncation; W=8 sums 0..510.
- err_count increments on each written sample with err=1. Dropped samples are not checked.
- Read, first-word-fall-through:
  - rd_valid = !empty; rd_data shows the head entry.
  - Pop when rd_valid && rd_ready.
  - rd_data is 0 when empty.
- Latency: a sample written at edge N has rd_valid=1 after edge N.
- Simultaneous push and pop: level unchanged; pointers both advance.
- Push and pop when empty: the write lands and level becomes 1. There is no bypass; the new sample is readable the next cycle.
- Pointers wrap modulo DEPTH using an extra MSB to distinguish full from empty.
- Counters saturate at 16'hFFFF.
- clr: pointers, level and counters go to 0 in the same cycle. A concurrent push or pop is discarded. State is unchanged.
- rst mid-operation: all state returns to reset values at the next edge, regardless of other inputs. rst has priority over clr, which has priority over push/pop.

Optional Feature:
- Macro: SUM_CAPTURE_TIMESTAMP_EN.
- When defined:
  - A 32-bit free-running cycle counter runs, reset to 0 and wrapping.
  - Each entry stores the counter value at the write edge.
  - rd_data widens to 3W+34 bits, with the timestamp in the MSBs.
- When undefined: no counter; rd_data is 3W+2 bits.

Decomposition:
- Package sum_capture_pkg:
  - state encoding localparams: IDLE=2'd0, CAPTURE=2'd1, STOPPED=2'd2;
  - counter width constant CNT_W=16;
  - timestamp width TS_W=32;
  - entry-width function of W.
- One natural sub-module: sum_capture_fifo. It is a generic FWFT circular buffer parameterised by width and depth, with push, pop, clr, level, full and empty. The top level owns the FSM, compare logic and counters.

Test Plan (W=8, DEPTH=4):
- Reset then samples with no arm: a=1, b=2, sum=3, in_valid=1 -> nothing captured; empty=1, level=0, capturing=0.
- arm, then 3 samples (1+2=3, 10+20=30, 255+255=510), then drain with rd_ready=1 -> rd_data in order, err=0 on all, err_count=0, empty=1 afterwards.
- arm, sample a=5, b=5, sum=9 -> err=1 in the entry; err_count=1.
- STOP_ON_FULL=0, arm, 6 samples, no reads -> full=1, level=4, drop_count=2; the first 4 samples are kept.
- Full FIFO with simultaneous push and pop -> level stays 4, no drop, oldest entry leaves, newest entry is appended; check the pointer wrap across 2 laps.
- Mid-capture: assert clr -> level=0 and counters=0 while capturing stays 1. Then assert rst -> capturing=0 and all outputs return to reset values.
